// File: rtl/aes_encipher_block_pkg.sv
// Shared AES constants, control-state encoding and GF(2^8) helpers for the
// encipher and decipher round datapaths.
package aes_encipher_block_pkg;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SBOX = 2'd2,
    MAIN = 2'd3
  } enc_state_t;

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction

endpackage

// File: rtl/aes_enc_mixw.sv
// Combinational MixColumns for one 32-bit state column (byte 0 in [31:24]).
module aes_enc_mixw
  import aes_encipher_block_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] mw
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = w[31:24];
  assign b1 = w[23:16];
  assign b2 = w[15:8];
  assign b3 = w[7:0];

  assign mw[31:24] = gm2(b0) ^ gm3(b1) ^ b2      ^ b3;
  assign mw[23:16] = b0      ^ gm2(b1) ^ gm3(b2) ^ b3;
  assign mw[15:8]  = b0      ^ b1      ^ gm2(b2) ^ gm3(b3);
  assign mw[7:0]   = gm3(b0) ^ b1      ^ b2      ^ gm2(b3);

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher round datapath using an external shared word S-box
// and external round-key memory. Optional `abort` input: AES_ENC_ABORT_EN.
module aes_encipher_block
  import aes_encipher_block_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
)
(
  input  logic         clk,
  input  logic         reset_n,
`ifdef AES_ENC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int unsigned SW = $clog2(NUM_WORDS);

  enc_state_t     state, state_new;
  logic [127:0]   block_reg, block_new;
  logic [3:0]     round_ctr, round_new;
  logic [SW-1:0]  sword_ctr, sword_new;
  logic           keylen_reg, keylen_new;
  logic           ready_reg, ready_new;

  logic [3:0]     nr;
  logic [127:0]   sr_block, mc_block;

  // Row r of the column-major state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned rr = 0; rr < 4; rr++) begin
        r[127 - 8*(4*c + rr) -: 8] = s[127 - 8*(4*((c + rr) % 4) + rr) -: 8];
      end
    end
    return r;
  endfunction

  assign nr       = (keylen_reg == AES_128_BIT_KEY) ? AES128_ROUNDS : AES256_ROUNDS;
  assign sr_block = shift_rows(block_reg);

  for (genvar g = 0; g < 4; g++) begin : g_mix
    aes_enc_mixw u_mixw (
      .w  (sr_block[127 - 32*g -: 32]),
      .mw (mc_block[127 - 32*g -: 32])
    );
  end

  always_comb begin
    sboxw = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (sword_ctr == i[SW-1:0]) sboxw = block_reg[127 - 32*i -: 32];
    end
  end

  assign round     = round_ctr;
  assign new_block = block_reg;
  assign ready     = ready_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      block_reg  <= '0;
      round_ctr  <= '0;
      sword_ctr  <= '0;
      keylen_reg <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state      <= state_new;
      block_reg  <= block_new;
      round_ctr  <= round_new;
      sword_ctr  <= sword_new;
      keylen_reg <= keylen_new;
      ready_reg  <= ready_new;
    end
  end

  always_comb begin
    state_new  = state;
    block_new  = block_reg;
    round_new  = round_ctr;
    sword_new  = sword_ctr;
    keylen_new = keylen_reg;
    ready_new  = ready_reg;

    case (state)
      IDLE: begin
        if (next) begin
          block_new  = block;
          keylen_new = keylen;
          round_new  = '0;
          ready_new  = 1'b0;
          state_new  = INIT;
        end
      end
      INIT: begin
        block_new = block_reg ^ round_key;
        round_new = 4'd1;
        sword_new = '0;
        state_new = SBOX;
      end
      SBOX: begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          if (sword_ctr == i[SW-1:0]) block_new[127 - 32*i -: 32] = new_sboxw;
        end
        sword_new = sword_ctr + 1'b1;
        if (sword_ctr == SW'(NUM_WORDS - 1)) state_new = MAIN;
      end
      MAIN: begin
        // The final round skips MixColumns and keeps round_ctr at Nr.
        if (round_ctr == nr) begin
          block_new = sr_block ^ round_key;
          ready_new = 1'b1;
          state_new = IDLE;
        end else begin
          block_new = mc_block ^ round_key;
          round_new = round_ctr + 4'd1;
          state_new = SBOX;
        end
      end
      default: state_new = IDLE;
    endcase

`ifdef AES_ENC_ABORT_EN
    if (abort && (state != IDLE)) begin
      state_new = IDLE;
      block_new = '0;
      round_new = '0;
      sword_new = '0;
      ready_new = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed FIPS-197 vectors for aes_encipher_block with a bench S-box and
// key-expansion model standing in for the shared S-box and key memory.
module tb_aes_encipher_block;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;
`ifdef AES_ENC_ABORT_EN
  logic         abort;
`endif

  typedef struct {
    logic         kl;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t         vecs [3];
  logic [7:0]   sbox_t [256];
  logic [127:0] rk [16];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  aes_encipher_block #(.NUM_WORDS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef AES_ENC_ABORT_EN
    .abort     (abort),
`endif
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  assign round_key = rk[round];
  assign new_sboxw = {sbox_t[sboxw[31:24]], sbox_t[sboxw[23:16]],
                      sbox_t[sboxw[15:8]],  sbox_t[sboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [7:0] l, r;
    l = x << k;
    r = x >> (8 - k);
    return l | r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, v8;
    for (int v = 0; v < 256; v++) begin
      v8  = 8'(v);
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, v8);
      end
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand(input logic kl, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nrr;
    nk  = kl ? 8 : 4;
    nrr = kl ? 14 : 10;
    rc  = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nrr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nrr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          rk[r] = '0;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input vec_t v);
    expand(v.kl, v.key);
    @(negedge clk);
    block  = v.pt;
    keylen = v.kl;
    next   = 1'b1;
    @(negedge clk);
    next = 1'b0;
    check("busy_after_next", 128'(ready), 128'(0));
  endtask

  // Returns the edge number (edge 1 samples next) at which ready rose, or
  // kill_e if that edge is reached first; poke_e>0 pulses next while busy.
  task automatic wait_done(input int nrr, input int poke_e, input int kill_e,
                           output int e, output bit rbad);
    int er;
    e = 1;
    rbad = 1'b0;
    while (!ready && e < 200) begin
      er = (e == 1) ? 0 : 1 + (e - 2) / 5;
      if (round !== 4'(er)) rbad = 1'b1;
      if (e == kill_e) return;
      if (poke_e > 0 && e == poke_e) begin
        next = 1'b1; block = ~block; keylen = ~keylen;
      end else if (poke_e > 0 && e == poke_e + 1) begin
        next = 1'b0; keylen = ~keylen;
      end
      @(negedge clk);
      e++;
    end
    if (ready && round !== 4'(nrr)) rbad = 1'b1;
  endtask

  initial begin
    int e;
    bit rbad;

    reset_n = 1'b1;
    next    = 1'b0;
    keylen  = 1'b0;
    block   = '0;
`ifdef AES_ENC_ABORT_EN
    abort   = 1'b0;
`endif
    build_sbox();

    vecs[0] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 52};
    vecs[1] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 52};
    vecs[2] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff,
                128'h8ea2b7ca516745bfeafc49904b496089, 72};

    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_new_block", new_block, '0);
    check("rst_round", 128'(round), 128'(0));
    check("rst_sboxw", 128'(sboxw), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      start(vecs[i]);
      wait_done(vecs[i].kl ? 14 : 10, 0, 0, e, rbad);
      check("latency", 128'(e), 128'(vecs[i].lat));
      check("round_seq", 128'(rbad), 128'(0));
      check("ciphertext", new_block, vecs[i].ct);
      repeat (3) @(negedge clk);
      check("hold_block", new_block, vecs[i].ct);
      check("hold_ready", 128'(ready), 128'(1));
    end

    // next pulsed mid-operation with a different block and keylen is ignored
    start(vecs[1]);
    wait_done(10, 20, 0, e, rbad);
    check("busy_next_latency", 128'(e), 128'(52));
    check("busy_next_ct", new_block, vecs[1].ct);

    // back-to-back: next asserted in the same cycle ready is seen high
    expand(vecs[0].kl, vecs[0].key);
    block  = vecs[0].pt;
    keylen = vecs[0].kl;
    next   = 1'b1;
    @(negedge clk);
    next = 1'b0;
    check("b2b_busy", 128'(ready), 128'(0));
    wait_done(10, 0, 0, e, rbad);
    check("b2b_latency", 128'(e), 128'(52));
    check("b2b_ct", new_block, vecs[0].ct);

    // asynchronous reset mid-operation
    start(vecs[1]);
    wait_done(10, 0, 30, e, rbad);
    check("reset_reach_edge", 128'(e), 128'(30));
    reset_n = 1'b0;
    #1;
    check("midrst_ready", 128'(ready), 128'(1));
    check("midrst_block", new_block, '0);
    check("midrst_round", 128'(round), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    start(vecs[1]);
    wait_done(10, 0, 0, e, rbad);
    check("post_rst_latency", 128'(e), 128'(52));
    check("post_rst_ct", new_block, vecs[1].ct);

`ifdef AES_ENC_ABORT_EN
    start(vecs[1]);
    wait_done(10, 0, 25, e, rbad);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", 128'(ready), 128'(1));
    check("abort_block", new_block, '0);
    check("abort_round", 128'(round), 128'(0));
    start(vecs[1]);
    wait_done(10, 0, 0, e, rbad);
    check("post_abort_latency", 128'(e), 128'(52));
    check("post_abort_ct", new_block, vecs[1].ct);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_encipher_block.md
Name: aes_encipher_block

Overview:
Iterative AES encipher datapath, the forward-direction counterpart of the decipher round logic. It runs the initial AddRoundKey, Nr-1 full rounds and a final round without MixColumns on one 128-bit block. Round keys come from the key memory, addressed by `round`. SubBytes uses one externally shared 32-bit S-box port, one word per cycle, so the S-box can be shared with key expansion.

Parameters:
- NUM_WORDS, 4, words per block; fixed at 4; used to size sword_ctr (2 bits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- next  in  1  start-encipher strobe, sampled only in IDLE
- keylen  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled with next
- round  out  4  round-key address, equal to round_ctr
- round_key  in  128  round key for `round`; combinational read, valid in the same cycle
- sboxw  out  32  word to S-box, equal to block_reg word sword_ctr
- new_sboxw  in  32  S-box result for sboxw; combinational, same cycle
- block  in  128  plaintext; byte 0 = [127:120], column-major state
- new_block  out  128  block_reg (ciphertext once ready)
- ready  out  1  high when idle and result valid

Behaviour:
- Reset values: block_reg=0, round_ctr=0, sword_ctr=0, keylen_reg=0, ready=1, state=IDLE. Outputs follow, so new_block=0, round=0, sboxw=0.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - next=1: block_reg<=block, keylen_reg<=keylen, round_ctr<=0, ready<=0, go to INIT.
  - next=0: hold all state.
- INIT: block_reg<=block_reg^round_key (round=0); round_ctr<=1; sword_ctr<=0; go to SBOX.
- SBOX:
  - Word sword_ctr of block_reg is replaced by new_sboxw. Word 0 = [127:96], word 3 = [31:0].
  - sword_ctr increments modulo 4.
  - After word 3 (sword_ctr wraps 3→0), go to MAIN.
- MAIN:
  - block_reg <= AddRoundKey(MixColumns(ShiftRows(block_reg))) using round_key at round=round_ctr.
  - If round_ctr==Nr, MixColumns is omitted, ready<=1 and the FSM goes to IDLE; round_ctr is held.
  - Otherwise round_ctr++ and the FSM goes to SBOX.
- ShiftRows: row r rotates left by r columns.
- MixColumns: matrix {2,3,1,1} per column; gm2(x) = {x[6:0],0} ^ (8'h1b & {8{x[7]}}); gm3 = gm2^x.
- Latency: counting the edge that samples next as edge 1, ready rises on edge 2+5·Nr. That is 52 for AES-128 and 72 for AES-256.
- ready is low for exactly 1+5·Nr cycles after acceptance.
- next while busy is ignored; there is no queueing.
- next held high across completion starts a new operation on the first IDLE cycle after ready rises.
- keylen changes while busy have no effect, because keylen_reg is used.
- Reset asserted mid-operation immediately forces the reset values, with no completion pulse.
- new_block is stable from ready rising until the next accepted next.

Optional Feature:
- AES_ENC_ABORT_EN
- When defined: adds input `abort` (1 bit).
  - abort=1 in INIT, SBOX or MAIN: the next edge sets block_reg=0, round_ctr=0, sword_ctr=0, ready=1, state=IDLE.
  - abort has priority over all state updates. It is ignored in IDLE, where next is still honoured.
- When undefined: the port does not exist and the behaviour is as above.

Decomposition:
- Shared package/include holds:
  - AES_128_BIT_KEY=0, AES_256_BIT_KEY=1
  - AES128_ROUNDS=10, AES256_ROUNDS=14
  - FSM state encodings: IDLE=0, INIT=1, SBOX=2, MAIN=3
  - gm2/gm3 functions, shared with the decipher side
- One sub-module: aes_enc_mixw, a combinational single-column MixColumns on 32 bits, instantiated 4×.
- The S-box is external; the key memory is external.

Test Plan:
- FIPS-197 App. B, AES-128, with a bench key-expansion model driving round_key:
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → new_block 3925841d02dc09fbdc118597196a0b32.
  - ready rises on edge 52.
- FIPS-197 C.1, AES-128: key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 C.3, AES-256: key 000102…1f, same pt → 8ea2b7ca516745bfeafc49904b496089.
  - ready rises on edge 72.
  - `round` sequences 0,1..14, each held for 5 cycles after INIT.
- Pulse next again at edge 20 of the C.1 run with a different block → ignored, C.1 result unchanged; then a back-to-back next on the ready cycle yields a correct second result.
- Deassert reset_n at edge 30 → ready=1, new_block=0 immediately; a fresh next afterwards gives the correct C.1 result.
- With AES_ENC_ABORT_EN: abort at edge 25 → ready=1 and new_block=0 on the next edge; the following C.1 run is correct.
